// File: rtl/running_average_scheduler.sv
// Round-robin arbiter feeding per-channel sliding-window averagers.
// One sample is accepted per cycle; its channel's windowed average is registered the next cycle.
module running_average_scheduler #(
  parameter int NUM_CH = 4,
  parameter int N      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req_valid_i,
  input  logic [NUM_CH*32-1:0]      req_data_i,
  output logic [NUM_CH-1:0]         req_ready_o,
  input  logic [NUM_CH-1:0]         clear_i,
  output logic                      avg_valid_o,
  output logic [$clog2(NUM_CH)-1:0] avg_ch_o,
  output logic [31:0]               avg_o,
  output logic                      avg_full_o
);

  localparam int CW = $clog2(NUM_CH);
  localparam int NW = $clog2(N);
  localparam logic [NW:0] FULL = (NW+1)'(N);

  // Per-channel window state
  logic [31:0]   r_buf   [NUM_CH][N];
  logic [NW-1:0] r_wptr  [NUM_CH];
  logic [NW:0]   r_count [NUM_CH];
  logic [31:0]   r_acc   [NUM_CH];
  logic [CW-1:0] r_rr_ptr;

  logic          r_avg_valid;
  logic          r_avg_full;
  logic [CW-1:0] r_avg_ch;
  logic [31:0]   r_avg;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_grant;
  logic              w_accept;
  logic [CW-1:0]     w_gnt_ch;
  logic [31:0]       w_data [NUM_CH];
  logic [31:0]       w_sel_data;
  logic              w_sel_full;
  logic [31:0]       w_evicted;
  logic [31:0]       w_acc_next;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_data[c] = req_data_i[32*c +: 32];
    end
  end

  // A channel being cleared steps aside so the search moves on within the same cycle.
  assign w_elig = req_valid_i & ~clear_i;

  always_comb begin : arbiter
    logic [CW-1:0] idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    idx      = '0;
    w_accept = 1'b0;
    w_gnt_ch = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = r_rr_ptr + CW'(i);
      if (!w_accept && w_elig[idx]) begin
        w_accept = 1'b1;
        w_gnt_ch = idx;
      end
    end
    w_grant = w_accept ? (NUM_CH'(1) << w_gnt_ch) : '0;
  end

  assign req_ready_o = w_grant;

  // Eviction only once the window is full; the partial window still divides by N.
  assign w_sel_data = w_data[w_gnt_ch];
  assign w_sel_full = (r_count[w_gnt_ch] == FULL);
  assign w_evicted  = w_sel_full ? r_buf[w_gnt_ch][r_wptr[w_gnt_ch]] : 32'd0;
  assign w_acc_next = r_acc[w_gnt_ch] + w_sel_data - w_evicted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c]  <= '0;
        r_count[c] <= '0;
        r_acc[c]   <= '0;
      end
      r_rr_ptr <= CW'(NUM_CH - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int c = 0; c < NUM_CH; c++) begin
        if (clear_i[c]) begin
          r_wptr[c]  <= '0;
          r_count[c] <= '0;
          r_acc[c]   <= '0;
        end else if (w_grant[c]) begin
          r_wptr[c] <= r_wptr[c] + 1'b1;
          r_acc[c]  <= w_acc_next;
          if (r_count[c] != FULL) begin
            r_count[c] <= r_count[c] + 1'b1;
          end
        end
      end
      if (w_accept) begin
        r_rr_ptr <= w_gnt_ch;
      end
    end
  end

  // NOTE: the sample memory has no reset; stale entries are never read until overwritten (count gates eviction).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[w_gnt_ch][r_wptr[w_gnt_ch]] <= w_sel_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_avg_valid <= 1'b0;
      r_avg_full  <= 1'b0;
      r_avg_ch    <= '0;
      r_avg       <= '0;
    end else begin
      r_avg_valid <= w_accept;
      r_avg_full  <= w_accept && w_sel_full;
      if (w_accept) begin
        r_avg_ch <= w_gnt_ch;
        r_avg    <= w_acc_next >> NW;
      end
    end
  end

  assign avg_valid_o = r_avg_valid;
  assign avg_full_o  = r_avg_full;
  assign avg_ch_o    = r_avg_ch;
  assign avg_o       = r_avg;

endmodule

// File: tb/tb_running_average_scheduler.sv
// Bench for running_average_scheduler: directed scenarios plus random traffic
// checked against a queue-based sliding-window reference model.
module tb_running_average_scheduler;

  localparam int NUM_CH = 4;
  localparam int N      = 4;
  localparam int CW     = $clog2(NUM_CH);
  localparam int LOGN   = $clog2(N);

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       req_valid_i;
  logic [NUM_CH*32-1:0]    req_data_i;
  logic [NUM_CH-1:0]       req_ready_o;
  logic [NUM_CH-1:0]       clear_i;
  logic                    avg_valid_o;
  logic [CW-1:0]           avg_ch_o;
  logic [31:0]             avg_o;
  logic                    avg_full_o;

  running_average_scheduler #(.NUM_CH(NUM_CH), .N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .clear_i     (clear_i),
    .avg_valid_o (avg_valid_o),
    .avg_ch_o    (avg_ch_o),
    .avg_o       (avg_o),
    .avg_full_o  (avg_full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the last up-to-N samples of each channel, oldest first.
  logic [31:0] win [NUM_CH][$];
  int          rr;
  logic [31:0] last_avg;
  int          last_ch;

  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) win[c].delete();
    rr       = NUM_CH - 1;
    last_avg = '0;
    last_ch  = 0;
  endtask

  function automatic logic [NUM_CH*32-1:0] lane(input int c, input logic [31:0] val);
    logic [NUM_CH*32-1:0] d;
    d = '0;
    d[32*c +: 32] = val;
    return d;
  endfunction

  // Called just after a rising edge; applies one cycle of stimulus and checks grant and result.
  task automatic step(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] clr,
                      input logic [NUM_CH*32-1:0] d);
    int                g;
    logic [NUM_CH-1:0] exp_ready;
    logic              full_before;
    logic [31:0]       sum;
    req_valid_i = v;
    clear_i     = clr;
    req_data_i  = d;
    @(negedge clk);
    g = -1;
    for (int i = 1; i <= NUM_CH; i++) begin
      int c;
      c = (rr + i) % NUM_CH;
      if (g < 0 && v[c] && !clr[c]) g = c;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("ready", 32'(req_ready_o), 32'(exp_ready));
    full_before = 1'b0;
    if (g >= 0) begin
      full_before = (win[g].size() == N);
      win[g].push_back(d[32*g +: 32]);
      if (win[g].size() > N) win[g].delete(0);
      sum = '0;
      for (int k = 0; k < win[g].size(); k++) sum = sum + win[g][k];
      last_avg = sum >> LOGN;
      last_ch  = g;
      rr       = g;
    end
    for (int c = 0; c < NUM_CH; c++) if (clr[c]) win[c].delete();
    @(posedge clk);
    #1;
    check("avg_valid", 32'(avg_valid_o), 32'(g >= 0));
    check("avg_full",  32'(avg_full_o),  32'(full_before));
    check("avg_ch",    32'(avg_ch_o),    32'(last_ch));
    check("avg",       avg_o,            last_avg);
  endtask

  task automatic do_reset();
    req_valid_i = '0;
    clear_i     = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(avg_valid_o), 32'd0);
    check({tag, "_avg"},   avg_o,            32'd0);
    check({tag, "_ch"},    32'(avg_ch_o),    32'd0);
    check({tag, "_full"},  32'(avg_full_o),  32'd0);
  endtask

  task automatic random_cycles(input int n);
    logic [NUM_CH-1:0]    v;
    logic [NUM_CH-1:0]    clr;
    logic [NUM_CH*32-1:0] d;
    for (int i = 0; i < n; i++) begin
      v   = NUM_CH'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
      for (int c = 0; c < NUM_CH; c++) begin
        d[32*c +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      end
      step(v, clr, d);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    req_valid_i = '0;
    clear_i     = '0;
    req_data_i  = '0;
    model_reset();

    // Reset state, and channel 0 has first priority out of reset
    reset = 1'b0;
    #12;
    check_outputs_zero("rst");
    req_valid_i = '1;
    #1;
    check("rst_ready", 32'(req_ready_o), 32'h1);
    req_valid_i = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Continuous requests on every channel rotate 0,1,2,3,...
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      step('1, '0, {NUM_CH{32'($urandom_range(0, 255))}});
      check("rr_order", 32'(avg_ch_o), 32'(k % NUM_CH));
    end

    // Single-channel fill and slide
    do_reset();
    begin
      logic [31:0] samples [5];
      logic [31:0] expect_avg [5];
      samples    = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20};
      expect_avg = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd14};
      for (int k = 0; k < 5; k++) begin
        step(4'b0001, '0, lane(0, samples[k]));
        check("fill_avg",  avg_o,              expect_avg[k]);
        check("fill_full", 32'(avg_full_o),    32'(k == 4));
      end
    end

    // Modulo-2^32 wrap, then eviction through a full window
    step('0, 4'b0001, '0);
    step(4'b0001, '0, lane(0, 32'hFFFF_FFFF));
    step(4'b0001, '0, lane(0, 32'h0000_0002));
    check("wrap_avg", avg_o, 32'd0);
    step(4'b0001, '0, lane(0, 32'hFFFF_FFF0));
    step(4'b0001, '0, lane(0, 32'h0000_0010));
    step(4'b0001, '0, lane(0, 32'h7FFF_FFFF));
    step(4'b0001, '0, lane(0, 32'h0000_0005));

    // Clearing ch2 leaves ch1 untouched
    step(4'b0010, '0, lane(1, 32'd20));
    step(4'b0010, '0, lane(1, 32'd20));
    for (int k = 0; k < 4; k++) step(4'b0100, '0, lane(2, 32'd100));
    check("ch2_full_avg", avg_o, 32'd100);
    step('0, 4'b0100, '0);
    step(4'b0100, '0, lane(2, 32'd40));
    check("clr_avg",  avg_o,           32'd10);
    check("clr_full", 32'(avg_full_o), 32'd0);
    step(4'b0010, '0, lane(1, 32'd20));
    check("ch1_kept", avg_o, 32'd15);

    // Clear and valid together on ch0: arbitration skips to ch1
    step(4'b0011, 4'b0001, lane(0, 32'd7) | lane(1, 32'd20));
    check("clr_skip_ch", 32'(avg_ch_o), 32'd1);
    check("clr_skip_avg", avg_o, 32'd20);

    random_cycles(400);

    // Mid-stream reset drops the pending result and restarts priority at ch0
    req_valid_i = '1;
    req_data_i  = {NUM_CH{32'd64}};
    #2;
    reset = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    req_valid_i = '0;
    reset       = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("midrst_idle", 32'(avg_valid_o), 32'd0);
    step('1, '0, {NUM_CH{32'd8}});
    check("midrst_ch",  32'(avg_ch_o), 32'd0);
    check("midrst_avg", avg_o,         32'd2);

    random_cycles(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/running_average_scheduler.md
RUNNING_AVERAGE_SCHEDULER -- requirements
Module: running_average_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of requester channels; power of 2, range 2..8.
REQ-002 Parameter N, default 4: averaging window depth per channel; power of 2, range 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  NUM_CH  per-channel sample request.
REQ-006 req_data_i  input  NUM_CH*32  per-channel sample; channel c occupies bits [32c+31:32c].
REQ-007 req_ready_o  output  NUM_CH  one-hot grant; a sample is accepted when valid and ready are both high in the same cycle.
REQ-008 clear_i  input  NUM_CH  per-channel synchronous window clear.
REQ-009 avg_valid_o  output  1  result strobe; high for exactly one cycle per accepted sample.
REQ-010 avg_ch_o  output  $clog2(NUM_CH)  channel index of the current result.
REQ-011 avg_o  output  32  running average of the current result's channel.
REQ-012 avg_full_o  output  1  high with avg_valid_o when that channel's window held N samples before the update.

Function
REQ-013 The block SHALL grant at most one channel per cycle, combinationally from req_valid_i, clear_i and the round-robin pointer.
REQ-014 Arbitration SHALL be round-robin: the search starts at the channel after the last granted one and wraps from NUM_CH-1 to 0.
REQ-015 The pointer SHALL advance to the granted channel only on an accepted sample; it SHALL hold in idle cycles.
REQ-016 A channel with clear_i high SHALL NOT be granted in that cycle; arbitration SHALL pass to the next eligible channel in the same cycle.
REQ-017 Each channel SHALL keep its own state: an N-entry 32-bit sample buffer, a $clog2(N)-bit write pointer, a fill count saturating at N, and a 32-bit accumulator.
REQ-018 On acceptance for channel c: acc_next = acc + data - evicted, where evicted is the buffer entry at the write pointer when count == N, and 0 otherwise.
REQ-019 On the same edge the block SHALL: write data at the write pointer; increment the pointer modulo N; increment count unless it equals N; register acc_next.
REQ-020 Accumulator arithmetic SHALL be modulo 2^32: overflow wraps and carries are discarded.
REQ-021 avg_o SHALL equal acc_next >> log2(N), including while count < N (the partial window is still divided by N).
REQ-022 Latency: avg_valid_o, avg_ch_o, avg_o and avg_full_o SHALL be registered and valid the cycle after acceptance.
REQ-023 Throughput: the block SHALL accept one sample per cycle, back-to-back, on the same or different channels.
REQ-024 The output has no backpressure; a result is presented for one cycle only.
REQ-025 When avg_valid_o is low, avg_o and avg_ch_o SHALL hold their last values.
REQ-026 clear_i[c] SHALL zero channel c's count, write pointer and accumulator on the next edge; the buffer contents need not be cleared.
REQ-027 Clearing one channel SHALL NOT affect the state of any other channel or any in-flight result.
REQ-028 A result already registered for a cleared channel SHALL still be presented.
REQ-029 A channel with count == N SHALL keep accepting samples; each one evicts the oldest sample (sliding window).

Reset
REQ-030 While reset is low: avg_valid_o=0, avg_o=0, avg_ch_o=0, avg_full_o=0, and every count, write pointer and accumulator SHALL be 0.
REQ-031 While reset is low, the round-robin pointer SHALL be NUM_CH-1, so that channel 0 has first priority after reset.
REQ-032 Sample buffers SHALL NOT require reset.
REQ-033 Reset asserted mid-stream SHALL drop any pending result; the first result after release SHALL reflect an empty window.

Verification
REQ-034 Single channel, N=4: ch0 samples 4,8,12,16,20 on consecutive cycles -> avg_o sequence 1,3,6,10,14 one cycle later; avg_full_o=1 only on the fifth result.
REQ-035 All four channels valid continuously -> grants ch0,1,2,3,0,1,... with one grant per cycle; avg_ch_o follows the same order one cycle later.
REQ-036 ch2 holds four samples of 100, then clear_i[2] is pulsed, then one sample of 40 -> result avg_o=10, avg_full_o=0; ch1 state is unchanged.
REQ-037 clear_i[0] and req_valid_i[0] high together with ch1 valid -> ch1 granted that cycle, ch0 not accepted.
REQ-038 Wrap: ch0 samples 0xFFFFFFFF, 0x00000002 -> accumulator 0x00000001, avg_o=0; then with full-window eviction the average matches the modulo-2^32 reference model.
REQ-039 reset pulsed low mid-stream -> outputs 0 immediately; next ch0 sample of 8 -> avg_o=2, and ch0 is granted first.
